// File: rtl/pipe_slice_pkg.sv
// Shared constants for the pipe_slice register slice: stage mode encodings
// and the occupancy counter width helper.
package pipe_slice_pkg;

    localparam int PS_MODE_FWD  = 0;
    localparam int PS_MODE_BWD  = 1;
    localparam int PS_MODE_FULL = 2;

    // Wide enough to count 0..2*depth held beats (MODE 2 capacity).
    function automatic int ps_occw(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slice_stage.sv
// One valid/ready register stage; MODE picks forward, backward (skid) or full slice.
// Valid/handshake: a beat moves on a cycle where valid & ready are both high.
module pipe_slice_stage
    import pipe_slice_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int MODE   = PS_MODE_FULL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready
);

    generate
        if (MODE == PS_MODE_FWD) begin : g_fwd
            logic              v;
            logic [DWIDTH-1:0] d;

            assign s_ready = ~v | m_ready;
            assign m_valid = v;
            assign m_data  = d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                end else if (flush) begin
                    v <= 1'b0;
                end else begin
                    v <= (s_valid & s_ready) | (v & ~m_ready);
                end
            end

            always_ff @(posedge clk) begin
                if (s_valid & s_ready) begin
                    d <= s_data;
                end
            end
        end else if (MODE == PS_MODE_BWD) begin : g_bwd
            logic              sv;
            logic [DWIDTH-1:0] sd;

            // Empty skid means the input passes straight through.
            assign s_ready = ~sv;
            assign m_valid = s_valid | sv;
            assign m_data  = sv ? sd : s_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sv <= 1'b0;
                end else if (flush) begin
                    sv <= 1'b0;
                end else if (m_ready) begin
                    sv <= 1'b0;
                end else if (s_valid & ~sv) begin
                    sv <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (s_valid & ~sv & ~m_ready) begin
                    sd <= s_data;
                end
            end
        end else begin : g_full
            logic              mv;
            logic              sv;
            logic [DWIDTH-1:0] md;
            logic [DWIDTH-1:0] sd;
            logic              accept;
            logic              main_free;

            assign accept    = s_valid & ~sv;
            assign main_free = ~mv | m_ready;
            assign s_ready   = ~sv;
            assign m_valid   = mv;
            assign m_data    = md;

            // The skid only fills while main is held, so sv implies mv.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mv <= 1'b0;
                    sv <= 1'b0;
                end else if (flush) begin
                    mv <= 1'b0;
                    sv <= 1'b0;
                end else if (main_free) begin
                    if (sv) begin
                        mv <= 1'b1;
                        sv <= 1'b0;
                    end else begin
                        mv <= accept;
                    end
                end else if (accept) begin
                    sv <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (main_free) begin
                    if (sv) begin
                        md <= sd;
                    end else if (accept) begin
                        md <= s_data;
                    end
                end else if (accept) begin
                    sd <= s_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_slice.sv
// Cascade of DEPTH pipe_slice_stage instances with synchronous flush.
// Defining PIPE_SLICE_OCC_EN adds the registered occupancy output occ.
module pipe_slice
    import pipe_slice_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1,
    parameter int MODE   = PS_MODE_FULL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready
`ifdef PIPE_SLICE_OCC_EN
    ,
    output logic [ps_occw(DEPTH)-1:0] occ
`endif
);

    generate
        if (MODE < PS_MODE_FWD || MODE > PS_MODE_FULL || DEPTH < 1 || DEPTH > 8) begin : g_bad_cfg
            $error("pipe_slice: MODE must be 0..2 and DEPTH 1..8");
        end
    endgenerate

    // Each stage keeps its own link signals so the combinational ready/valid
    // chains stay separate nets per stage.
    for (genvar k = 0; k < DEPTH; k++) begin : g_st
        logic              in_v;
        logic              in_r;
        logic [DWIDTH-1:0] in_d;
        logic              out_v;
        logic              out_r;
        logic [DWIDTH-1:0] out_d;

        if (k == 0) begin : g_head
            assign in_v = s_valid & ~flush;
            assign in_d = s_data;
        end else begin : g_link
            assign in_v = g_st[k-1].out_v;
            assign in_d = g_st[k-1].out_d;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign out_r = m_ready & ~flush;
        end else begin : g_next
            assign out_r = g_st[k+1].in_r;
        end

        pipe_slice_stage #(
            .DWIDTH (DWIDTH),
            .MODE   (MODE)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .s_valid (in_v),
            .s_data  (in_d),
            .s_ready (in_r),
            .m_valid (out_v),
            .m_data  (out_d),
            .m_ready (out_r)
        );
    end

    assign s_ready = g_st[0].in_r & ~flush;
    assign m_valid = g_st[DEPTH-1].out_v & ~flush;
    assign m_data  = g_st[DEPTH-1].out_d;

`ifdef PIPE_SLICE_OCC_EN
    localparam int OCCW = ps_occw(DEPTH);
    localparam logic [OCCW-1:0] OCC_ONE = OCCW'(1);

    logic            s_fire;
    logic            m_fire;
    logic [OCCW-1:0] occ_q;

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (s_fire & ~m_fire) begin
            occ_q <= occ_q + OCC_ONE;
        end else if (m_fire & ~s_fire) begin
            occ_q <= occ_q - OCC_ONE;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_slice.sv
// Bench for pipe_slice: 24 instances covering MODE 0..2 x DEPTH 1..8 (8-bit payload).
// Instance index = MODE*8 + DEPTH-1. Optional occ checks follow PIPE_SLICE_OCC_EN.
module tb_pipe_slice;

    localparam int NI = 24;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid_a [NI];
    logic [DW-1:0] s_data_a  [NI];
    logic          s_ready_a [NI];
    logic          m_valid_a [NI];
    logic [DW-1:0] m_data_a  [NI];
    logic          m_ready_a [NI];
    logic          flush_a   [NI];
`ifdef PIPE_SLICE_OCC_EN
    logic [4:0]    occ_a     [NI];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int M = g / 8;
        localparam int D = (g % 8) + 1;
`ifdef PIPE_SLICE_OCC_EN
        logic [$clog2(2*D+1)-1:0] occ_l;
        assign occ_a[g] = 5'(occ_l);
`endif
        pipe_slice #(
            .DWIDTH (DW),
            .DEPTH  (D),
            .MODE   (M)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush_a[g]),
            .s_valid (s_valid_a[g]),
            .s_data  (s_data_a[g]),
            .s_ready (s_ready_a[g]),
            .m_valid (m_valid_a[g]),
            .m_data  (m_data_a[g]),
            .m_ready (m_ready_a[g])
`ifdef PIPE_SLICE_OCC_EN
            ,
            .occ     (occ_l)
`endif
        );
    end

    // driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            s_valid_a[i] = 1'b0;
            s_data_a[i]  = '0;
            m_ready_a[i] = 1'b0;
            flush_a[i]   = 1'b0;
        end
    endtask

    typedef struct {
        int          idx;
        logic        sv;
        logic [7:0]  sd;
        logic        mr;
        logic        fl;
        logic        e_sr;
        logic        e_mv;
        logic [7:0]  e_md;
        int          e_occ;
    } vec_t;

    function automatic vec_t mk(input int idx, input logic sv, input logic [7:0] sd,
                                input logic mr, input logic fl, input logic e_sr,
                                input logic e_mv, input logic [7:0] e_md, input int e_occ);
        vec_t v;
        v.idx = idx; v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_occ = e_occ;
        return v;
    endfunction

    // scoreboard state for the random phase
    logic [DW-1:0] exp_q [NI][$];
    logic          hold_v [NI];
    logic [DW-1:0] hold_d [NI];
    logic          acc    [NI];

    vec_t tbl [22];

    initial begin
        int i;
        int sent, got, first_acc, first_out, last_out, gaps, cyc, n_acc, pct;
        logic [7:0] nxt;

        idle_all();
        for (int k = 0; k < NI; k++) begin
            hold_v[k] = 1'b0;
            hold_d[k] = '0;
            acc[k]    = 1'b0;
        end

        // MODE1 DEPTH1 (idx 8): pass-through, skid, then flush of a held skid beat
        tbl[0]  = mk(8, 1, 8'hAA, 1, 0, 1, 1, 8'hAA, 0);
        tbl[1]  = mk(8, 1, 8'hBB, 0, 0, 1, 1, 8'hBB, 0);
        tbl[2]  = mk(8, 0, 8'h00, 0, 0, 0, 1, 8'hBB, 1);
        tbl[3]  = mk(8, 1, 8'hCC, 0, 0, 0, 1, 8'hBB, 1);
        tbl[4]  = mk(8, 1, 8'hCC, 1, 0, 0, 1, 8'hBB, 1);
        tbl[5]  = mk(8, 1, 8'hCC, 1, 0, 1, 1, 8'hCC, 0);
        tbl[6]  = mk(8, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        tbl[7]  = mk(8, 1, 8'hDD, 0, 0, 1, 1, 8'hDD, 0);
        tbl[8]  = mk(8, 1, 8'hEE, 1, 1, 0, 0, 8'h00, 1);
        tbl[9]  = mk(8, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        // MODE0 DEPTH4 (idx 3): fill four beats, flush with valid/ready high, resume
        tbl[10] = mk(3, 1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
        tbl[11] = mk(3, 1, 8'h02, 0, 0, 1, 0, 8'h00, 1);
        tbl[12] = mk(3, 1, 8'h03, 0, 0, 1, 0, 8'h00, 2);
        tbl[13] = mk(3, 1, 8'h04, 0, 0, 1, 0, 8'h00, 3);
        tbl[14] = mk(3, 1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
        tbl[15] = mk(3, 1, 8'h05, 1, 1, 0, 0, 8'h00, 4);
        tbl[16] = mk(3, 1, 8'h05, 1, 0, 1, 0, 8'h00, 0);
        tbl[17] = mk(3, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[18] = mk(3, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[19] = mk(3, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[20] = mk(3, 0, 8'h00, 1, 0, 1, 1, 8'h05, 1);
        tbl[21] = mk(3, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state of every configuration
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset dut%0d s_ready", k), 32'(s_ready_a[k]), 32'd1);
            chk($sformatf("reset dut%0d m_valid", k), 32'(m_valid_a[k]), 32'd0);
`ifdef PIPE_SLICE_OCC_EN
            chk($sformatf("reset dut%0d occ", k), 32'(occ_a[k]), 32'd0);
`endif
        end

        // table-driven vectors
        for (int r = 0; r < 22; r++) begin
            @(posedge clk);
            #1;
            i = tbl[r].idx;
            s_valid_a[i] = tbl[r].sv;
            s_data_a[i]  = tbl[r].sd;
            m_ready_a[i] = tbl[r].mr;
            flush_a[i]   = tbl[r].fl;
            @(negedge clk);
            chk($sformatf("vec%0d s_ready", r), 32'(s_ready_a[i]), 32'(tbl[r].e_sr));
            chk($sformatf("vec%0d m_valid", r), 32'(m_valid_a[i]), 32'(tbl[r].e_mv));
            if (tbl[r].e_mv)
                chk($sformatf("vec%0d m_data", r), 32'(m_data_a[i]), 32'(tbl[r].e_md));
`ifdef PIPE_SLICE_OCC_EN
            chk($sformatf("vec%0d occ", r), 32'(occ_a[i]), 32'(tbl[r].e_occ));
`endif
        end
        @(posedge clk);
        #1;
        idle_all();

        // MODE2 DEPTH3 (idx 18): 16-beat stream, latency and no gaps
        i = 18;
        sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1; gaps = 0; cyc = 0;
        m_ready_a[i] = 1'b1;
        while (got < 16 && cyc < 100) begin
            @(posedge clk);
            #1;
            s_valid_a[i] = (sent < 16);
            s_data_a[i]  = 8'(sent + 1);
            @(negedge clk);
            if (m_valid_a[i] && m_ready_a[i]) begin
                chk($sformatf("stream beat%0d data", got), 32'(m_data_a[i]), 32'(got + 1));
                if (first_out < 0) first_out = cyc;
                else if (cyc != last_out + 1) gaps++;
                last_out = cyc;
                got++;
            end
            if (s_valid_a[i] && s_ready_a[i]) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            cyc++;
        end
        chk("stream beats received", 32'(got), 32'd16);
        chk("stream latency", 32'(first_out - first_acc), 32'd3);
        chk("stream gaps", 32'(gaps), 32'd0);
        @(posedge clk);
        #1;
        idle_all();

        // MODE2 DEPTH2 (idx 17): backpressure fill then ordered drain
        i = 17;
        n_acc = 0; nxt = 8'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            s_valid_a[i] = 1'b1;
            s_data_a[i]  = nxt;
            @(negedge clk);
            if (s_valid_a[i] && s_ready_a[i]) begin
                n_acc++;
                nxt++;
            end
        end
        chk("backpressure accepted", 32'(n_acc), 32'd4);
        chk("backpressure s_ready", 32'(s_ready_a[i]), 32'd0);
        chk("backpressure m_data held", 32'(m_data_a[i]), 32'd1);
`ifdef PIPE_SLICE_OCC_EN
        chk("backpressure occ", 32'(occ_a[i]), 32'd4);
`endif
        @(posedge clk);
        #1;
        s_valid_a[i] = 1'b0;
        m_ready_a[i] = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid_a[i] && m_ready_a[i]) begin
                chk($sformatf("drain beat%0d data", got), 32'(m_data_a[i]), 32'(got + 1));
                got++;
            end
            @(posedge clk);
        end
        chk("drain beats received", 32'(got), 32'd4);
        #1;
        idle_all();

        // random valid/ready on all 24 configurations
        for (int c = 0; c < 1700; c++) begin
            pct = (c < 600) ? 80 : ((c < 1100) ? 30 : 60);
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (!s_valid_a[k] || acc[k]) begin
                    s_valid_a[k] = ($urandom_range(0, 3) != 0);
                    s_data_a[k]  = 8'($urandom_range(0, 255));
                end
                m_ready_a[k] = ($urandom_range(0, 99) < pct);
            end
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
`ifdef PIPE_SLICE_OCC_EN
                chk($sformatf("rand dut%0d occ", k), 32'(occ_a[k]), 32'(exp_q[k].size()));
`endif
                if (hold_v[k]) begin
                    chk($sformatf("rand dut%0d stall m_valid", k), 32'(m_valid_a[k]), 32'd1);
                    chk($sformatf("rand dut%0d stall m_data", k), 32'(m_data_a[k]), 32'(hold_d[k]));
                end
                acc[k] = s_valid_a[k] & s_ready_a[k];
                if (acc[k]) exp_q[k].push_back(s_data_a[k]);
                if (m_valid_a[k] && m_ready_a[k]) begin
                    chk($sformatf("rand dut%0d beat expected", k), 32'(exp_q[k].size() != 0), 32'd1);
                    if (exp_q[k].size() != 0)
                        chk($sformatf("rand dut%0d data", k), 32'(m_data_a[k]), 32'(exp_q[k].pop_front()));
                end
                hold_v[k] = m_valid_a[k] & ~m_ready_a[k];
                hold_d[k] = m_data_a[k];
            end
        end

        // drain: finish pending offers, then empty every slice
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (acc[k]) s_valid_a[k] = 1'b0;
                m_ready_a[k] = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                acc[k] = s_valid_a[k] & s_ready_a[k];
                if (acc[k]) exp_q[k].push_back(s_data_a[k]);
                if (m_valid_a[k] && m_ready_a[k]) begin
                    chk($sformatf("drain dut%0d beat expected", k), 32'(exp_q[k].size() != 0), 32'd1);
                    if (exp_q[k].size() != 0)
                        chk($sformatf("drain dut%0d data", k), 32'(m_data_a[k]), 32'(exp_q[k].pop_front()));
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("final dut%0d beats outstanding", k), 32'(exp_q[k].size()), 32'd0);
            chk($sformatf("final dut%0d m_valid", k), 32'(m_valid_a[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        idle_all();

        // asynchronous reset mid-stream on MODE2 DEPTH2 (idx 17)
        i = 17;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            s_valid_a[i] = 1'b1;
            s_data_a[i]  = 8'(8'h30 + c);
        end
        @(negedge clk);
        chk("pre-reset m_valid", 32'(m_valid_a[i]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset m_valid", 32'(m_valid_a[i]), 32'd0);
        chk("async reset s_ready", 32'(s_ready_a[i]), 32'd1);
        s_valid_a[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_valid_a[i] = 1'b1;
        s_data_a[i]  = 8'h5A;
        m_ready_a[i] = 1'b1;
        @(negedge clk);
        chk("post-reset accept s_ready", 32'(s_ready_a[i]), 32'd1);
        @(posedge clk);
        #1;
        s_valid_a[i] = 1'b0;
        @(negedge clk);
        chk("post-reset latency m_valid early", 32'(m_valid_a[i]), 32'd0);
        @(negedge clk);
        chk("post-reset m_valid", 32'(m_valid_a[i]), 32'd1);
        chk("post-reset m_data", 32'(m_data_a[i]), 32'h5A);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
